// File: rtl/stream_chk_pkg.sv
// Shared types and helpers for the serial word checker.
//   state_e  : controller states (IDLE, RUN, DONE)
//   mod3_t   : running remainder of the word value modulo 3 (0..2)
//   PATTERN  : three-bit pattern searched for in the word
//   mod3_step: one-bit update of the modulo-3 remainder
package stream_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [1:0] mod3_t;

  localparam logic [2:0] PATTERN = 3'b010;

  // 2^k mod 3 is 1 for even k and 2 for odd k; the result stays within 0..2.
  function automatic mod3_t mod3_step(input mod3_t r, input logic b, input logic odd_idx);
    mod3_t res;
    res = r;
    if (b) begin
      if (odd_idx) begin
        case (r)
          2'd0:    res = 2'd2;
          2'd1:    res = 2'd0;
          default: res = 2'd1;
        endcase
      end else begin
        case (r)
          2'd0:    res = 2'd1;
          2'd1:    res = 2'd2;
          default: res = 2'd0;
        endcase
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_chk_accum.sv
// Per-beat accumulator for the three word flags.
//   clk, rst      : clock, synchronous active-high reset
//   clr_i         : clear all accumulated state (new word)
//   en_i          : consume bit_i this cycle
//   bit_i         : serial data bit at index k
//   odd_idx_i     : k is odd
//   hist_ok_i     : k >= 2, so the two-bit history is meaningful
//   rem_c_o       : remainder including the current beat (combinational)
//   par_c_o       : odd-index parity including the current beat (combinational)
//   found_c_o     : pattern-found flag including the current beat (combinational)
module stream_chk_accum
  import stream_chk_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr_i,
  input  logic  en_i,
  input  logic  bit_i,
  input  logic  odd_idx_i,
  input  logic  hist_ok_i,
  output mod3_t rem_c_o,
  output logic  par_c_o,
  output logic  found_c_o
);

  mod3_t      rem_q, rem_d;
  logic       par_q, par_d;
  logic [1:0] hist_q, hist_d;   // [1] = bit k-2, [0] = bit k-1
  logic       found_q, found_d;

  // Next-state of all accumulators for the current beat.
  always_comb begin
    rem_d   = rem_q;
    par_d   = par_q;
    hist_d  = hist_q;
    found_d = found_q;
    if (en_i) begin
      rem_d   = mod3_step(rem_q, bit_i, odd_idx_i);
      par_d   = par_q ^ (bit_i & odd_idx_i);
      hist_d  = {hist_q[0], bit_i};
      found_d = found_q | (hist_ok_i & ({hist_q, bit_i} == PATTERN));
    end
  end

  // Accumulator registers; clear takes priority over enable.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      rem_q   <= '0;
      par_q   <= 1'b0;
      hist_q  <= '0;
      found_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      par_q   <= par_d;
      hist_q  <= hist_d;
      found_q <= found_d;
    end
  end

  // Expose the post-beat values so the top can latch results on the last beat.
  assign rem_c_o   = rem_d;
  assign par_c_o   = par_d;
  assign found_c_o = found_d;

endmodule

// File: rtl/stream_word_checker.sv
// Serial word checker: accepts an N-bit word LSB first over a valid/ready
// bit stream and reports divisibility by 3, odd parity of the odd-indexed
// bits and presence of the pattern 010.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a new word (honoured only in IDLE)
//   in_bit, in_valid    : serial bit input, qualified by in_valid
//   in_ready            : high while a word is being received
//   out_valid, out_ready: result handshake, result held until accepted
//   res_mult3           : word value mod 3 == 0
//   res_odd_par         : odd number of ones at odd bit indices
//   res_pat010          : some A[i+2:i] == 3'b010
//   busy                : high while receiving or holding a result
module stream_word_checker
  import stream_chk_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic res_mult3,
  output logic res_odd_par,
  output logic res_pat010,
  output logic busy
);

  localparam int unsigned   KW     = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [KW-1:0] K_TWO  = KW'(2);

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic          mult3_q;
  logic          odd_par_q;
  logic          pat010_q;

  logic  beat_c;
  logic  clr_c;
  mod3_t rem_c;
  logic  par_c;
  logic  found_c;

  assign beat_c = in_valid & in_ready_q;
  assign clr_c  = (state_q == IDLE) & start;

  stream_chk_accum u_accum (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (clr_c),
    .en_i      (beat_c),
    .bit_i     (in_bit),
    .odd_idx_i (k_q[0]),
    .hist_ok_i (k_q >= K_TWO),
    .rem_c_o   (rem_c),
    .par_c_o   (par_c),
    .found_c_o (found_c)
  );

  // Controller: state, beat counter, handshake and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mult3_q     <= 1'b0;
      odd_par_q   <= 1'b0;
      pat010_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= RUN;
            k_q        <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            mult3_q    <= 1'b0;
            odd_par_q  <= 1'b0;
            pat010_q   <= 1'b0;
          end
        end
        RUN: begin
          if (beat_c) begin
            if (k_q == K_LAST) begin
              // Last bit: latch flags including this beat.
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              mult3_q     <= (rem_c == 2'd0);
              odd_par_q   <= par_c;
              pat010_q    <= found_c;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign busy        = busy_q;
  assign res_mult3   = mult3_q;
  assign res_odd_par = odd_par_q;
  assign res_pat010  = pat010_q;

endmodule
